branch_prediction_ctrl: RTL and testbench

Dynamic branch prediction and misprediction-recovery controller for the 5-stage RISC-V pipeline. In Fetch, it looks up a direct-mapped BHT/BTB (2-bit saturating counters, tags, targets) and supplies a predicted next PC. In Execute, it compares the prediction against the resolved branch decision from the branching unit, updates the table, and drives redirect and flush to the hazard/PC logic. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_prediction_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_prediction_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_prediction_ctrl.sv
// Dynamic branch predictor: direct-mapped BHT/BTB looked up in Fetch, trained and
// checked in Execute, with redirect/flush generation and saturating statistics.
module branch_prediction_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  // Fetch-side lookup
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  // Execute-side resolve
  input  logic             BranchE,
  input  logic             TakebranchE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      PCPlus4E,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  output logic             MispredictE,
  output logic [31:0]      RedirectPCE,
  output logic             FlushD,
  output logic             FlushE,
  // Statistics
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  // Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_SNT = 2'b00;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_BITS-1:0]   w_tag_f;
  logic                  w_hit_f;
  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TAG_BITS-1:0]   w_tag_e;
  logic                  w_hit_e;
  logic                  w_dir_wrong;
  logic                  w_tgt_wrong;
  logic                  w_mispredict;
  logic                  w_unused;

  assign w_idx_f = PCF[TAG_LSB-1:2];
  assign w_tag_f = PCF[TAG_MSB:TAG_LSB];
  assign w_idx_e = PCE[TAG_LSB-1:2];
  assign w_tag_e = PCE[TAG_MSB:TAG_LSB];

  assign w_unused = ^{PCF[31:TAG_MSB+1], PCF[1:0], PCE[31:TAG_MSB+1], PCE[1:0]};

  // Fetch lookup reads only registered table state, so an update landing in the
  // same cycle is not bypassed; Fetch sees it from the following cycle.
  assign w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : (PCF + 32'd4);

  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  // A correct direction with a stale target still needs a redirect.
  assign w_dir_wrong  = (TakebranchE != PredTakenE);
  assign w_tgt_wrong  = TakebranchE && PredTakenE && (PredTargetE != PCTargetE);
  assign w_mispredict = BranchE && (w_dir_wrong || w_tgt_wrong);

  assign MispredictE = w_mispredict;
  assign RedirectPCE = w_mispredict ? (TakebranchE ? PCTargetE : PCPlus4E) : 32'd0;
  assign FlushD      = w_mispredict;
  assign FlushE      = w_mispredict;

  assign BranchCount  = r_branch_cnt;
  assign MispredCount = r_mispred_cnt;

  // Table training: hits move the counter; only taken misses allocate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (BranchE) begin
      if (w_hit_e) begin
        if (TakebranchE) begin
          r_ctr[w_idx_e]    <= (r_ctr[w_idx_e] == CTR_ST) ? CTR_ST : (r_ctr[w_idx_e] + 2'd1);
          r_target[w_idx_e] <= PCTargetE;
        end else begin
          r_ctr[w_idx_e]    <= (r_ctr[w_idx_e] == CTR_SNT) ? CTR_SNT : (r_ctr[w_idx_e] - 2'd1);
        end
      end else if (TakebranchE) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= PCTargetE;
        r_ctr[w_idx_e]    <= CTR_WT;
      end
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (BranchE) begin
      if (!(&r_branch_cnt)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_mispredict && !(&r_mispred_cnt)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_prediction_ctrl.sv
// Directed bench for branch_prediction_ctrl: a driver queues hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_branch_prediction_ctrl;

  localparam int W = 1 + 32 + 1 + 32 + 1 + 1 + 16 + 16 + 4 + 4;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        BranchE;
  logic        Branch2E;
  logic        TakebranchE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic [31:0] PCPlus4E;
  logic        PredTakenE;
  logic [31:0] PredTargetE;

  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;
  logic [15:0] BranchCount;
  logic [15:0] MispredCount;

  logic        s_PredTakenF;
  logic [31:0] s_PredTargetF;
  logic        s_MispredictE;
  logic [31:0] s_RedirectPCE;
  logic        s_FlushD;
  logic        s_FlushE;
  logic [3:0]  s_BranchCount;
  logic [3:0]  s_MispredCount;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec;
  int           n_miss;

  branch_prediction_ctrl #(.INDEX_BITS(4), .TAG_BITS(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .TakebranchE(TakebranchE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .FlushD(FlushD), .FlushE(FlushE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  // Narrow-counter instance for the saturation case.
  branch_prediction_ctrl #(.INDEX_BITS(4), .TAG_BITS(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .PCF(PCF),
    .PredTakenF(s_PredTakenF), .PredTargetF(s_PredTargetF),
    .BranchE(Branch2E), .TakebranchE(TakebranchE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(s_MispredictE), .RedirectPCE(s_RedirectPCE),
    .FlushD(s_FlushD), .FlushE(s_FlushE),
    .BranchCount(s_BranchCount), .MispredCount(s_MispredCount)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Driver: one vector per cycle, inputs applied just after the rising edge.
  task automatic vec(input string nm, input logic rst, input logic [31:0] pcf,
                     input logic br, input logic tk, input logic [31:0] pce,
                     input logic [31:0] tgt, input logic pte, input logic [31:0] ptg,
                     input logic br2, input logic e_ptf, input logic [31:0] e_ptgt,
                     input logic e_mis, input logic [31:0] e_red,
                     input logic [15:0] e_bc, input logic [15:0] e_mc,
                     input logic [3:0] e_sbc, input logic [3:0] e_smc);
    @(posedge clk);
    #1;
    reset       = rst;
    PCF         = pcf;
    BranchE     = br;
    Branch2E    = br2;
    TakebranchE = tk;
    PCE         = pce;
    PCTargetE   = tgt;
    PCPlus4E    = pce + 32'd4;
    PredTakenE  = pte;
    PredTargetE = ptg;
    exp_q.push_back({e_ptf, e_ptgt, e_mis, e_red, e_mis, e_mis, e_bc, e_mc, e_sbc, e_smc});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {PredTakenF, PredTargetF, MispredictE, RedirectPCE, FlushD, FlushE,
               BranchCount, MispredCount, s_BranchCount, s_MispredCount};
      n_vec++;
      if (act_v !== exp_v) begin
        n_miss++;
        $display("FAIL %s: got ptf=%b ptgt=%h mis=%b red=%h fd=%b fe=%b bc=%0d mc=%0d sbc=%0d smc=%0d, expected ptf=%b ptgt=%h mis=%b red=%h fd=%b fe=%b bc=%0d mc=%0d sbc=%0d smc=%0d",
                 nm, act_v[107], act_v[106:75], act_v[74], act_v[73:42], act_v[41], act_v[40],
                 act_v[39:24], act_v[23:8], act_v[7:4], act_v[3:0],
                 exp_v[107], exp_v[106:75], exp_v[74], exp_v[73:42], exp_v[41], exp_v[40],
                 exp_v[39:24], exp_v[23:8], exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset = 1'b1; PCF = 32'h100; BranchE = 1'b0; Branch2E = 1'b0; TakebranchE = 1'b0;
    PCE = '0; PCTargetE = '0; PCPlus4E = 32'd4; PredTakenE = 1'b0; PredTargetE = '0;
    repeat (2) @(posedge clk);

    //   name                  rst pcf       br tk pce      tgt       pte ptg      b2 ptf ptgt      mis red       bc mc sbc smc
    vec("reset_state",         0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h000, 0, 0, 0, 0);
    vec("cold_taken",          0, 32'h100, 1, 1, 32'h100, 32'h080, 0, 32'h104, 0, 0, 32'h104, 1, 32'h080, 0, 0, 0, 0);
    vec("predict_alloc",       0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h080, 0, 32'h000, 1, 1, 0, 0);
    vec("taken_hit1",          0, 32'h100, 1, 1, 32'h100, 32'h080, 1, 32'h080, 0, 1, 32'h080, 0, 32'h000, 1, 1, 0, 0);
    vec("taken_hit2",          0, 32'h100, 1, 1, 32'h100, 32'h080, 1, 32'h080, 0, 1, 32'h080, 0, 32'h000, 2, 1, 0, 0);
    vec("taken_hit3",          0, 32'h100, 1, 1, 32'h100, 32'h080, 1, 32'h080, 0, 1, 32'h080, 0, 32'h000, 3, 1, 0, 0);
    vec("not_taken1",          0, 32'h100, 1, 0, 32'h100, 32'h080, 1, 32'h080, 0, 1, 32'h080, 1, 32'h104, 4, 1, 0, 0);
    vec("still_taken",         0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h080, 0, 32'h000, 5, 2, 0, 0);
    vec("not_taken2",          0, 32'h100, 1, 0, 32'h100, 32'h080, 1, 32'h080, 0, 1, 32'h080, 1, 32'h104, 5, 2, 0, 0);
    vec("weak_nt_lookup",      0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h000, 6, 3, 0, 0);
    vec("wrong_target",        0, 32'h100, 1, 1, 32'h100, 32'h090, 1, 32'h080, 0, 0, 32'h104, 1, 32'h090, 6, 3, 0, 0);
    vec("new_target",          0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h090, 0, 32'h000, 7, 4, 0, 0);
    vec("alias_same_cycle",    0, 32'h100, 1, 1, 32'h140, 32'h200, 0, 32'h144, 0, 1, 32'h090, 1, 32'h200, 7, 4, 0, 0);
    vec("alias_miss",          0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h000, 8, 5, 0, 0);
    vec("alias_hit",           0, 32'h140, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h200, 0, 32'h000, 8, 5, 0, 0);
    vec("miss_not_taken",      0, 32'h140, 1, 0, 32'h300, 32'h400, 0, 32'h304, 0, 1, 32'h200, 0, 32'h000, 8, 5, 0, 0);
    vec("entry_kept",          0, 32'h140, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h200, 0, 32'h000, 9, 5, 0, 0);
    vec("nt_no_alloc",         0, 32'h300, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h304, 0, 32'h000, 9, 5, 0, 0);
    vec("brancheE_low",        0, 32'h300, 0, 1, 32'h100, 32'h080, 0, 32'h104, 0, 0, 32'h304, 0, 32'h000, 9, 5, 0, 0);
    vec("after_branchE_low",   0, 32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h104, 0, 32'h000, 9, 5, 0, 0);
    vec("async_reset",         1, 32'h140, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 32'h144, 0, 32'h000, 0, 0, 0, 0);
    vec("stats_b1",            0, 32'h200, 1, 1, 32'h104, 32'h040, 0, 32'h108, 0, 0, 32'h204, 1, 32'h040, 0, 0, 0, 0);
    vec("stats_b2",            0, 32'h104, 1, 1, 32'h104, 32'h040, 1, 32'h040, 0, 1, 32'h040, 0, 32'h000, 1, 1, 0, 0);
    vec("stats_b3",            0, 32'h104, 1, 1, 32'h104, 32'h040, 1, 32'h040, 0, 1, 32'h040, 0, 32'h000, 2, 1, 0, 0);
    vec("stats_b4",            0, 32'h104, 1, 0, 32'h108, 32'h010, 0, 32'h10c, 0, 1, 32'h040, 0, 32'h000, 3, 1, 0, 0);
    vec("stats_b5",            0, 32'h104, 1, 0, 32'h104, 32'h040, 1, 32'h040, 0, 1, 32'h040, 1, 32'h108, 4, 1, 0, 0);
    vec("stats_total",         0, 32'h104, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h040, 0, 32'h000, 5, 2, 0, 0);

    // Narrow counters: count up to 15 then hold.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e_cnt;
      e_cnt = (i > 15) ? 4'd15 : 4'(i);
      vec($sformatf("sat_%0d", i), 0, 32'h104, 0, 1, 32'h500, 32'h600, 0, 32'h504, 1,
          1, 32'h040, 0, 32'h000, 5, 2, e_cnt, e_cnt);
    end
    vec("sat_hold",            0, 32'h104, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 1, 32'h040, 0, 32'h000, 5, 2, 15, 15);

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_miss++;
        $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
      end
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
